fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_if.sv | 21 ++
 rtl/fifo_wr_arb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_if.sv
// Write-port bundle: four byte requesters on one side, the FIFO write port on the other.
// The arbiter takes the slave view; requesters and FIFO model take the master view.
interface fifo_wr_arb_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        w_full;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        w_en;
    logic [7:0]  w_data;

    modport master (
        output req, req_data, w_full,
        input  grant, ack, w_en, w_data
    );

    modport slave (
        input  req, req_data, w_full,
        output grant, ack, w_en, w_data
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter for four byte requesters sharing one FIFO write port.
// Optional macro FIFO_WR_ARB_PRIO_EN gives requester 0 fixed priority over 1..3.
module fifo_wr_arb #(
    parameter int unsigned BURST_LEN = 4
) (
    input logic          w_clk,
    input logic          rst_n,
    fifo_wr_arb_if.slave arb_io
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [4:0] BurstLast = 5'(BURST_LEN);

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [4:0] beat_q, beat_d;
    logic [1:0] last_q, last_d;

    logic [1:0] owner;
    logic [1:0] winner;
    logic       wen;
    logic [3:0] ack;
    logic [7:0] wdata;
    logic       last_beat;
    logic       owner_drop;

    // State register
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 4'b0000;
            beat_q  <= 5'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        owner = 2'd0;
        unique case (grant_q)
            4'b0010: owner = 2'd1;
            4'b0100: owner = 2'd2;
            4'b1000: owner = 2'd3;
            default: owner = 2'd0;
        endcase
    end

`ifdef FIFO_WR_ARB_PRIO_EN
    // Requester 0 always wins; 1..3 rotate behind it, so last_q only ever holds 1..3.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        winner = 2'd0;
        found  = 1'b0;
        cand   = last_q;
        if (!arb_io.req[0]) begin
            for (int k = 0; k < 3; k++) begin
                cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
                if (!found && arb_io.req[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        logic [1:0] cand;
        logic       found;
        winner = 2'd0;
        found  = 1'b0;
        cand   = last_q;
        for (int k = 0; k < 4; k++) begin
            cand = cand + 2'd1;
            if (!found && arb_io.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

    assign last_beat  = (beat_q + 5'd1) == BurstLast;
    assign owner_drop = !arb_io.req[owner];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (arb_io.req != 4'b0000) begin
                    state_d = StGrant;
                    grant_d = 4'b0001 << winner;
                    beat_d  = 5'd0;
                end
            end
            StGrant: begin
                if (wen) begin
                    beat_d = beat_q + 5'd1;
                end
                if (owner_drop || (wen && last_beat)) begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                    beat_d  = 5'd0;
`ifdef FIFO_WR_ARB_PRIO_EN
                    if (owner != 2'd0) begin
                        last_d = owner;
                    end
`else
                    last_d = owner;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    // Output logic: purely from registered ownership plus live req/full/data.
    always_comb begin
        wen   = 1'b0;
        ack   = 4'b0000;
        wdata = 8'h00;
        if (state_q == StGrant) begin
            wen   = arb_io.req[owner] & ~arb_io.w_full;
            wdata = arb_io.req_data[{owner, 3'b000} +: 8];
            ack   = {4{wen}} & grant_q;
        end
    end

    assign arb_io.grant  = grant_q;
    assign arb_io.ack    = ack;
    assign arb_io.w_en   = wen;
    assign arb_io.w_data = wdata;

    assert property (@(posedge w_clk) disable iff (!rst_n) $onehot0(grant_q));

    assert property (@(posedge w_clk) disable iff (!rst_n)
        wen |-> (grant_q != 4'b0000 && !arb_io.w_full));

    assert property (@(posedge w_clk) disable iff (!rst_n) beat_q <= BurstLast);

    // A stalled owner keeps the port until its word goes in.
    assert property (@(posedge w_clk) disable iff (!rst_n)
        (state_q == StGrant && arb_io.w_full && !owner_drop) |=> (grant_q == $past(grant_q)));

endmodule
